// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing the multi-cycle datapath around one shared memory port.
// Define PERF_COUNTER_EN to build the retired-instruction counter driven on instr_count.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [1:0]       mode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             base_write,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             sp_inc,
    output logic             sp_dec,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        WBB    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_JMP,
        C_JR, C_CALL, C_RET, C_PUSH, C_POP, C_ILL
    } cls_t;

    localparam int              WD_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [2:0]      ALU_ADD = 3'b001;
    localparam logic [2:0]      ALU_SUB = 3'b010;

    state_t          state_q, state_d;
    logic [5:0]      opc_q, opc_d;
    logic [1:0]      mode_q, mode_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            pend_q, pend_d;

    logic [5:0]      cur_opc;
    logic [1:0]      cur_mode;
    cls_t            cls;
    logic            post_inc;
    logic            timeout;

    function automatic cls_t classify(input logic [5:0] op, input logic [1:0] md);
        cls_t c;
        c = C_ILL;
        casez (op)
            6'b0000??: c = C_RTYPE;
            6'b0001??: c = (md == 2'b11) ? C_ILL : C_IALU;
            6'b001000: c = (md == 2'b11) ? C_ILL : C_LW;
            6'b001001: c = (md == 2'b11) ? C_ILL : C_SW;
            6'b001010: c = C_BEQ;
            6'b001011: c = C_BNE;
            6'b001111: c = C_JMP;
            6'b010010: c = C_JR;
            6'b010000: c = C_CALL;
            6'b010001: c = C_RET;
            6'b010100: c = C_PUSH;
            6'b010101: c = C_POP;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    always_comb begin
        // The IR only holds the new instruction from DECODE on; later states use the captured copy.
        cur_opc  = (state_q == DECODE) ? opcode : opc_q;
        cur_mode = (state_q == DECODE) ? mode : mode_q;
        cls      = classify(cur_opc, cur_mode);
        post_inc = (cur_mode == 2'b01);
        timeout  = (TIMEOUT != 0) && (wd_q == WD_MAX);

        state_d    = state_q;
        opc_d      = opc_q;
        mode_d     = mode_q;
        pend_d     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 2'b00;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        base_write = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;

        case (state_q)
            INIT: state_d = FETCH;
            FETCH: begin
                if (timeout) begin
                    bus_err = 1'b1;
                end else if (run || pend_q) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            DECODE: begin
                opc_d  = opcode;
                mode_d = mode;
                case (cls)
                    C_RTYPE, C_IALU, C_LW, C_SW, C_BEQ, C_BNE: state_d = EXEC;
                    C_JMP, C_JR: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        state_d  = FETCH;
                    end
                    C_CALL, C_RET, C_PUSH, C_POP: state_d = MEM;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            EXEC: begin
                state_d = FETCH;
                case (cls)
                    C_RTYPE: begin
                        alu_op  = {1'b0, cur_opc[1:0]};
                        state_d = WB;
                    end
                    C_IALU: begin
                        alu_src = 1'b1;
                        alu_op  = {1'b0, cur_opc[1:0]};
                        state_d = WB;
                    end
                    C_LW, C_SW: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                        state_d = MEM;
                    end
                    C_BEQ, C_BNE: begin
                        alu_op = ALU_SUB;
                        if ((cls == C_BEQ) == zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                if (timeout) begin
                    bus_err = 1'b1;
                    state_d = FETCH;
                end else begin
                    mem_req = 1'b1;
                    case (cls)
                        C_LW: begin
                            addr_sel = 2'b01;
                            if (mem_ready) state_d = WB;
                        end
                        C_SW: begin
                            addr_sel = 2'b01;
                            mem_we   = 1'b1;
                            if (mem_ready) state_d = post_inc ? WBB : FETCH;
                        end
                        C_CALL: begin
                            addr_sel = 2'b10;
                            mem_we   = 1'b1;
                            if (mem_ready) begin
                                sp_dec   = 1'b1;
                                pc_write = 1'b1;
                                pc_src   = 2'b10;
                                state_d  = FETCH;
                            end
                        end
                        C_RET: begin
                            addr_sel = 2'b10;
                            if (mem_ready) begin
                                sp_inc   = 1'b1;
                                pc_write = 1'b1;
                                pc_src   = 2'b11;
                                state_d  = FETCH;
                            end
                        end
                        C_PUSH: begin
                            addr_sel = 2'b10;
                            mem_we   = 1'b1;
                            if (mem_ready) begin
                                sp_dec  = 1'b1;
                                state_d = FETCH;
                            end
                        end
                        C_POP: begin
                            addr_sel = 2'b10;
                            if (mem_ready) begin
                                sp_inc  = 1'b1;
                                state_d = WB;
                            end
                        end
                        default: begin
                            mem_req = 1'b0;
                            state_d = FETCH;
                        end
                    endcase
                end
            end
            WB: begin
                reg_write = 1'b1;
                wb_sel    = (cls == C_LW || cls == C_POP) ? 2'b01 : 2'b00;
                state_d   = (cls == C_LW && post_inc) ? WBB : FETCH;
            end
            WBB: begin
                base_write = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = INIT;
        endcase

        // Watchdog measures one wait at a time; a bus error restarts it even without a state change.
        if (state_d != state_q || bus_err) begin
            wd_d = '0;
        end else if (TIMEOUT != 0 && mem_req && !mem_ready) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = wd_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            opc_q   <= '0;
            mode_q  <= '0;
            wd_q    <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            mode_q  <= mode_d;
            wd_q    <= wd_d;
            pend_q  <= pend_d;
        end
    end

    assign state_o = state_q;

`ifdef PERF_COUNTER_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    always_comb begin
        retire = (state_d == FETCH) && (state_q != FETCH) && (state_q != INIT)
                 && !illegal && !bus_err;
        cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected output vectors are queued per scenario and
// compared on the falling edge; the DUT runs with TIMEOUT=4.
module tb_multicycle_ctrl;

    localparam int         CNT_W    = 32;
    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_WBB    = 3'd6;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic [1:0] asel;
        logic       irw;
        logic       pcw;
        logic [1:0] psrc;
        logic       rw;
        logic [1:0] wsel;
        logic       bw;
        logic       asrc;
        logic [2:0] aop;
        logic       spi;
        logic       spd;
        logic       ill;
        logic       berr;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b1;
    logic [5:0]       opcode = 6'd0;
    logic [1:0]       mode = 2'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, ir_write, pc_write, reg_write, base_write;
    logic             alu_src, sp_inc, sp_dec, illegal, bus_err;
    logic [1:0]       addr_sel, pc_src, wb_sel;
    logic [2:0]       alu_op, state_o;
    logic [CNT_W-1:0] instr_count;

    obs_t  act;
    obs_t  e_mon;
    obs_t  exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    retired  = 0;
    string tag = "init";

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mode(mode),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .base_write(base_write), .alu_src(alu_src),
        .alu_op(alu_op), .sp_inc(sp_inc), .sp_dec(sp_dec), .illegal(illegal),
        .bus_err(bus_err), .state_o(state_o), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign act = {state_o, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
                  wb_sel, base_write, alu_src, alu_op, sp_inc, sp_dec, illegal, bus_err};

    // Scoreboard: one queued expectation per clock cycle, consumed mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            n_checks++;
            if (act !== e_mon) begin
                n_errors++;
                $display("FAIL %s: outputs got %h (state %0d) expected %h (state %0d)",
                         tag, act, act.st, e_mon, e_mon.st);
            end
        end
    end

    function automatic obs_t o(input logic [2:0] st);
        obs_t r;
        r = '0;
        r.st = st;
        return r;
    endfunction

    function automatic obs_t f_hit();
        obs_t r;
        r = o(S_FETCH);
        r.req = 1'b1;
        r.irw = 1'b1;
        r.pcw = 1'b1;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef PERF_COUNTER_EN
        return CNT_W'(retired);
`else
        return '0;
`endif
    endfunction

    task automatic tick(input logic rdy, input logic zr);
        mem_ready = rdy;
        zero      = zr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tag = "reset";
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(o(S_INIT));
        tick(1'b1, 1'b0);
        reset = 1'b0;
        exp_q.push_back(o(S_INIT));
        tick(1'b1, 1'b0);
        n_checks++;
        if (instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL reset_count: instr_count=%0d expected %0d", instr_count, exp_cnt());
        end
    endtask

    task automatic test_add();
        obs_t x;
        tag = "add";
        opcode = 6'b000001;
        mode   = 2'b00;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.aop = 3'b001; exp_q.push_back(x);
        x = o(S_WB); x.rw = 1'b1; exp_q.push_back(x);
        repeat (4) tick(1'b1, 1'b0);
        retired++;
        n_checks++;
        if (instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL add_count: instr_count=%0d expected %0d", instr_count, exp_cnt());
        end
    endtask

    task automatic test_lw_postinc();
        obs_t x;
        tag = "lw_postinc";
        opcode = 6'b001000;
        mode   = 2'b01;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.asrc = 1'b1; x.aop = 3'b001; exp_q.push_back(x);
        x = o(S_MEM); x.req = 1'b1; x.asel = 2'b01;
        repeat (4) exp_q.push_back(x);
        x = o(S_WB); x.rw = 1'b1; x.wsel = 2'b01; exp_q.push_back(x);
        x = o(S_WBB); x.bw = 1'b1; exp_q.push_back(x);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        opcode = 6'b111111;
        mode   = 2'b11;
        tick(1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        retired++;
        n_checks++;
        if (state_o !== S_FETCH) begin
            n_errors++;
            $display("FAIL lw_postinc_end: state=%0d expected %0d", state_o, S_FETCH);
        end
    endtask

    task automatic test_branch();
        obs_t x;
        tag = "beq_taken";
        opcode = 6'b001010;
        mode   = 2'b00;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.aop = 3'b010; x.pcw = 1'b1; x.psrc = 2'b01; exp_q.push_back(x);
        repeat (3) tick(1'b1, 1'b1);
        tag = "bne_not_taken";
        opcode = 6'b001011;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.aop = 3'b010; exp_q.push_back(x);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tag = "bne_taken";
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.aop = 3'b010; x.pcw = 1'b1; x.psrc = 2'b01; exp_q.push_back(x);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        retired += 3;
        n_checks++;
        if (instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL branch_count: instr_count=%0d expected %0d", instr_count, exp_cnt());
        end
    endtask

    task automatic test_call_ret();
        obs_t x;
        tag = "call";
        opcode = 6'b010000;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_MEM); x.req = 1'b1; x.we = 1'b1; x.asel = 2'b10; x.spd = 1'b1;
        x.pcw = 1'b1; x.psrc = 2'b10; exp_q.push_back(x);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tag = "ret";
        opcode = 6'b010001;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_MEM); x.req = 1'b1; x.asel = 2'b10; x.spi = 1'b1;
        x.pcw = 1'b1; x.psrc = 2'b11; exp_q.push_back(x);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        retired += 2;
        n_checks++;
        if (instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL call_ret_count: instr_count=%0d expected %0d", instr_count, exp_cnt());
        end
    endtask

    task automatic test_stack_misc();
        obs_t x;
        tag = "push";
        opcode = 6'b010100;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_MEM); x.req = 1'b1; x.we = 1'b1; x.asel = 2'b10; exp_q.push_back(x);
        x.spd = 1'b1; exp_q.push_back(x);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        tag = "pop";
        opcode = 6'b010101;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_MEM); x.req = 1'b1; x.asel = 2'b10; x.spi = 1'b1; exp_q.push_back(x);
        x = o(S_WB); x.rw = 1'b1; x.wsel = 2'b01; exp_q.push_back(x);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tag = "jmp_jr";
        x = o(S_DECODE); x.pcw = 1'b1; x.psrc = 2'b10;
        opcode = 6'b001111;
        exp_q.push_back(f_hit()); exp_q.push_back(x);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        opcode = 6'b010010;
        exp_q.push_back(f_hit()); exp_q.push_back(x);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tag = "sw_postinc";
        opcode = 6'b001001;
        mode   = 2'b01;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.asrc = 1'b1; x.aop = 3'b001; exp_q.push_back(x);
        x = o(S_MEM); x.req = 1'b1; x.we = 1'b1; x.asel = 2'b01; exp_q.push_back(x);
        x = o(S_WBB); x.bw = 1'b1; exp_q.push_back(x);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tag = "ialu_mode10";
        opcode = 6'b000111;
        mode   = 2'b10;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.asrc = 1'b1; x.aop = 3'b011; exp_q.push_back(x);
        x = o(S_WB); x.rw = 1'b1; exp_q.push_back(x);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        mode = 2'b00;
        retired += 6;
        n_checks++;
        if (instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL stack_misc_count: instr_count=%0d expected %0d", instr_count, exp_cnt());
        end
    endtask

    task automatic test_illegal();
        obs_t x;
        tag = "illegal_opcode";
        opcode = 6'b111111;
        mode   = 2'b00;
        x = o(S_DECODE); x.ill = 1'b1;
        exp_q.push_back(f_hit()); exp_q.push_back(x);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        tag = "illegal_mode";
        opcode = 6'b001000;
        mode   = 2'b11;
        exp_q.push_back(f_hit()); exp_q.push_back(x);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        mode = 2'b00;
        tag = "run_park";
        run = 1'b0;
        exp_q.push_back(o(S_FETCH)); exp_q.push_back(o(S_FETCH));
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        run = 1'b1;
        n_checks++;
        if (instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL illegal_count: instr_count=%0d expected %0d", instr_count, exp_cnt());
        end
    endtask

    task automatic test_timeout();
        obs_t x;
        tag = "fetch_timeout";
        opcode = 6'b000001;
        x = o(S_FETCH); x.req = 1'b1;
        repeat (4) exp_q.push_back(x);
        x = o(S_FETCH); x.berr = 1'b1; exp_q.push_back(x);
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.aop = 3'b001; exp_q.push_back(x);
        x = o(S_WB); x.rw = 1'b1; exp_q.push_back(x);
        repeat (5) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        retired++;
        tag = "mem_timeout";
        opcode = 6'b001000;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.asrc = 1'b1; x.aop = 3'b001; exp_q.push_back(x);
        x = o(S_MEM); x.req = 1'b1; x.asel = 2'b01;
        repeat (4) exp_q.push_back(x);
        x = o(S_MEM); x.berr = 1'b1; exp_q.push_back(x);
        tick(1'b1, 1'b0);
        repeat (7) tick(1'b0, 1'b0);
        n_checks++;
        if (state_o !== S_FETCH || instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL timeout_end: state=%0d count=%0d expected state %0d count %0d",
                     state_o, instr_count, S_FETCH, exp_cnt());
        end
    endtask

    task automatic test_reset_mid();
        obs_t x;
        tag = "reset_mid";
        opcode = 6'b001000;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.asrc = 1'b1; x.aop = 3'b001; exp_q.push_back(x);
        x = o(S_MEM); x.req = 1'b1; x.asel = 2'b01; exp_q.push_back(x);
        tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        retired = 0;
        n_checks++;
        if (act !== o(S_INIT) || instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL reset_mid_async: outputs got %h count %0d expected %h count %0d",
                     act, instr_count, o(S_INIT), exp_cnt());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(o(S_INIT));
        tick(1'b1, 1'b0);
        tag = "after_reset_add";
        opcode = 6'b000001;
        exp_q.push_back(f_hit());
        exp_q.push_back(o(S_DECODE));
        x = o(S_EXEC); x.aop = 3'b001; exp_q.push_back(x);
        x = o(S_WB); x.rw = 1'b1; exp_q.push_back(x);
        repeat (4) tick(1'b1, 1'b0);
        retired++;
        n_checks++;
        if (instr_count !== exp_cnt()) begin
            n_errors++;
            $display("FAIL after_reset_count: instr_count=%0d expected %0d", instr_count, exp_cnt());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_lw_postinc();
        test_branch();
        test_call_ret();
        test_stack_misc();
        test_illegal();
        test_timeout();
        test_reset_mid();
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
